// File: rtl/sha1_rx_pkg.sv
// Shared constants, state encoding and block payload type for the SHA-1 receive-side block sequencer.
package sha1_rx_pkg;

   localparam int unsigned BLK_W     = 512;
   localparam int unsigned BLK_BYTES = 64;
   localparam int unsigned LEN_SLOT  = 56;
   localparam int unsigned IDX_W     = 7;
   localparam logic [7:0]  PAD_BYTE  = 8'h80;

   // FSM encoding kept as plain constants for compatibility with existing tooling
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COLLECT = 3'd1;
   localparam logic [2:0] S_SEND    = 3'd2;
   localparam logic [2:0] S_PAD     = 3'd3;
   localparam logic [2:0] S_SEND_P1 = 3'd4;
   localparam logic [2:0] S_SEND_P2 = 3'd5;

   // Block payload presented to the hash core
   typedef struct packed {
      logic [BLK_W-1:0] data;
      logic             first;
      logic             last;
   } blk_t;

   // Insert byte b at big-endian slot idx (slot 0 occupies the top byte)
   function automatic logic [BLK_W-1:0] put_byte(input logic [BLK_W-1:0] blk,
                                                  input logic [5:0]       idx,
                                                  input logic [7:0]       b);
      logic [BLK_W-1:0] r;
      r = blk;
      for (int i = 0; i < int'(BLK_BYTES); i++) begin
         if (idx == 6'(i)) r[int'(BLK_W) - 1 - 8*i -: 8] = b;
      end
      return r;
   endfunction

endpackage

// File: rtl/sha1_rx_idle_timer.sv
// Idle timer: counts enabled cycles since the last clear and strobes expire_c
// on the cycle the count reaches IDLE_TIMEOUT-1. A clear in the same cycle wins.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   clr         restart count from zero (a byte was taken this cycle)
//   en          timer active (message being collected)
//   expire_c    combinational one-cycle expiry strobe
module sha1_rx_idle_timer #(
   parameter int unsigned IDLE_TIMEOUT = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire_c
);

   localparam int unsigned      TMR_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] LAST  = TMR_W'(IDLE_TIMEOUT - 1);

   logic [TMR_W-1:0] cnt_q;

   // Count idle cycles; parks at LAST since the FSM leaves collection on expiry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr || !en) begin
         cnt_q <= '0;
      end else if (cnt_q != LAST) begin
         cnt_q <= cnt_q + TMR_W'(1);
      end
   end

   assign expire_c = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/sha1_rx_block_ctrl.sv
// Packs UART RX bytes big-endian into 512-bit SHA-1 blocks, closes a message on
// idle timeout, appends SHA-1 padding plus the 64-bit bit length, and hands the
// blocks to the hash core over a valid/ready handshake.
// Optional feature: define SHA1_RX_EOM_CHAR_EN to make EOM_CHAR a message
// terminator (not stored) instead of ordinary data.
// Ports:
//   clk, rst_n    clock / async active-low reset
//   rx_done_tick  one-cycle strobe, rx_byte valid
//   rx_byte       received byte
//   blk_valid     block outputs valid; held until accepted
//   blk_ready     core accepts block when blk_valid && blk_ready
//   blk_data      512-bit block, first byte in [511:504]
//   blk_first     block is the first of its message
//   blk_last      block is the final padded block of its message
//   busy          controller not idle
//   overrun       sticky byte-dropped flag, cleared by reset only
module sha1_rx_block_ctrl
   import sha1_rx_pkg::*;
#(
   parameter int unsigned IDLE_TIMEOUT = 100000,
   parameter int unsigned CNT_W        = 32,
   parameter logic [7:0]  EOM_CHAR     = 8'h0A
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_done_tick,
   input  logic [7:0]       rx_byte,
   output logic             blk_valid,
   input  logic             blk_ready,
   output logic [BLK_W-1:0] blk_data,
   output logic             blk_first,
   output logic             blk_last,
   output logic             busy,
   output logic             overrun
);

`ifdef SHA1_RX_EOM_CHAR_EN
   localparam logic EOM_EN = 1'b1;
`else
   localparam logic EOM_EN = 1'b0;
`endif

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [2:0]       state_q, state_d;
   blk_t             blk_q, blk_d;
   logic             valid_q, valid_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             first_pend_q, first_pend_d;
   logic             hold_vld_q, hold_vld_d;
   logic [7:0]       hold_byte_q, hold_byte_d;
   logic             overrun_q, overrun_d;
   logic             busy_q;

   logic             take_src_c;
   logic             src_vld_c;
   logic [7:0]       src_byte_c;
   logic             eom_hit_c;
   logic             accept_c;
   logic [63:0]      len_c;
   logic             tmr_en_c;
   logic             tmr_expire_c;

   // The held byte is always older than a same-cycle tick, so it is consumed first
   assign take_src_c = (state_q == S_IDLE) || (state_q == S_COLLECT);
   assign src_vld_c  = take_src_c && (hold_vld_q || rx_done_tick);
   assign src_byte_c = hold_vld_q ? hold_byte_q : rx_byte;
   assign eom_hit_c  = EOM_EN && (src_byte_c == EOM_CHAR);
   assign accept_c   = valid_q && blk_ready;
   assign len_c      = 64'({cnt_q, 3'b000});
   assign tmr_en_c   = (state_q == S_COLLECT);

   sha1_rx_idle_timer #(
      .IDLE_TIMEOUT (IDLE_TIMEOUT)
   ) u_idle_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (src_vld_c),
      .en       (tmr_en_c),
      .expire_c (tmr_expire_c)
   );

   // Next-state and datapath update
   always_comb begin
      state_d      = state_q;
      blk_d        = blk_q;
      valid_d      = valid_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      first_pend_d = first_pend_q;
      hold_vld_d   = hold_vld_q;
      hold_byte_d  = hold_byte_q;
      overrun_d    = overrun_q;

      case (state_q)
         S_IDLE, S_COLLECT: begin
            // Hold drains this cycle; a concurrent tick refills it
            if (hold_vld_q) begin
               hold_vld_d  = rx_done_tick;
               hold_byte_d = rx_byte;
            end
            if (src_vld_c) begin
               if (eom_hit_c) begin
                  state_d = S_PAD;
               end else if (cnt_q == CNT_MAX) begin
                  overrun_d = 1'b1;
               end else begin
                  blk_d.data = put_byte(blk_q.data, idx_q[5:0], src_byte_c);
                  idx_d      = idx_q + IDX_W'(1);
                  cnt_d      = cnt_q + CNT_W'(1);
                  state_d    = S_COLLECT;
                  if (idx_q == IDX_W'(BLK_BYTES - 1)) begin
                     state_d     = S_SEND;
                     valid_d     = 1'b1;
                     blk_d.first = first_pend_q;
                     blk_d.last  = 1'b0;
                  end
               end
            end else if (tmr_expire_c) begin
               state_d = S_PAD;
            end
         end

         S_SEND: begin
            if (accept_c) begin
               valid_d      = 1'b0;
               blk_d        = '0;
               idx_d        = '0;
               first_pend_d = 1'b0;
               state_d      = S_COLLECT;
            end
         end

         // Terminator byte, then length here if it fits, else in an extra block
         S_PAD: begin
            blk_d.data  = put_byte(blk_q.data, idx_q[5:0], PAD_BYTE);
            blk_d.first = first_pend_q;
            valid_d     = 1'b1;
            if (idx_q < IDX_W'(LEN_SLOT)) begin
               blk_d.data[63:0] = len_c;
               blk_d.last       = 1'b1;
               state_d          = S_SEND_P2;
            end else begin
               blk_d.last = 1'b0;
               state_d    = S_SEND_P1;
            end
         end

         S_SEND_P1: begin
            if (accept_c) begin
               blk_d.data       = '0;
               blk_d.data[63:0] = len_c;
               blk_d.first      = 1'b0;
               blk_d.last       = 1'b1;
               first_pend_d     = 1'b0;
               state_d          = S_SEND_P2;
            end
         end

         S_SEND_P2: begin
            if (accept_c) begin
               valid_d      = 1'b0;
               blk_d        = '0;
               idx_d        = '0;
               cnt_d        = '0;
               first_pend_d = 1'b1;
               state_d      = hold_vld_q ? S_COLLECT : S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Bytes arriving while a block is pending go to the one-deep hold
      if (!take_src_c && rx_done_tick) begin
         if (hold_vld_q) begin
            overrun_d = 1'b1;
         end else begin
            hold_vld_d  = 1'b1;
            hold_byte_d = rx_byte;
         end
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         blk_q        <= '0;
         valid_q      <= 1'b0;
         idx_q        <= '0;
         cnt_q        <= '0;
         first_pend_q <= 1'b1;
         hold_vld_q   <= 1'b0;
         hold_byte_q  <= '0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         blk_q        <= blk_d;
         valid_q      <= valid_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         first_pend_q <= first_pend_d;
         hold_vld_q   <= hold_vld_d;
         hold_byte_q  <= hold_byte_d;
         overrun_q    <= overrun_d;
         busy_q       <= (state_d != S_IDLE);
      end
   end

   assign blk_valid = valid_q;
   assign blk_data  = blk_q.data;
   assign blk_first = blk_q.first;
   assign blk_last  = blk_q.last;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_sha1_rx_block_ctrl.sv
// Bench for sha1_rx_block_ctrl: reference model is plain SHA-1 message padding
// applied to the byte stream the bench sent.
`timescale 1ns/1ps
module tb_sha1_rx_block_ctrl;

   localparam int unsigned TO = 50;

   typedef struct packed {
      logic [511:0] data;
      logic         first;
      logic         last;
   } rec_t;

   typedef struct {
      int unsigned len;
      logic [7:0]  base;
      bit          incr;
      int unsigned nblk;
      logic [63:0] len_bits;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         rx_done_tick = 1'b0;
   logic [7:0]   rx_byte = 8'h00;
   logic         blk_ready = 1'b0;
   logic         blk_valid;
   logic [511:0] blk_data;
   logic         blk_first;
   logic         blk_last;
   logic         busy;
   logic         overrun;

   always #5 clk = ~clk;

   sha1_rx_block_ctrl #(.IDLE_TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_done_tick (rx_done_tick),
      .rx_byte      (rx_byte),
      .blk_valid    (blk_valid),
      .blk_ready    (blk_ready),
      .blk_data     (blk_data),
      .blk_first    (blk_first),
      .blk_last     (blk_last),
      .busy         (busy),
      .overrun      (overrun)
   );

   rec_t       got_q[$];
   rec_t       exp_q[$];
   rec_t       cap;
   logic [7:0] msg_q[$];
   int         nvec = 0;
   int         nerr = 0;
   int         rdy_mode = 1;
   int         low_run = 0;

   // Record every accepted block (ready only changes just after posedge)
   always @(negedge clk) begin
      if (rst_n && blk_valid && blk_ready) begin
         cap.data  = blk_data;
         cap.first = blk_first;
         cap.last  = blk_last;
         got_q.push_back(cap);
      end
   end

   // Ready driver: 0 low, 1 high, 2 random with at most two low cycles in a row
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: blk_ready = 1'b0;
            1: blk_ready = 1'b1;
            default: begin
               if (low_run >= 2) blk_ready = 1'b1;
               else blk_ready = ($urandom_range(0, 3) != 0);
               low_run = blk_ready ? 0 : low_run + 1;
            end
         endcase
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [7:0] fix(input logic [7:0] b);
`ifdef SHA1_RX_EOM_CHAR_EN
      return (b == 8'h0A) ? 8'h0B : b;
`else
      return b;
`endif
   endfunction

   // SHA-1 padding of msg_q: 0x80, zeros to 56 mod 64, 64-bit bit length
   function automatic void build_exp();
      logic [7:0]  p[$];
      logic [63:0] bits;
      int          nb;
      rec_t        r;
      exp_q.delete();
      p    = msg_q;
      bits = 64'(msg_q.size()) * 64'd8;
      p.push_back(8'h80);
      while ((p.size() % 64) != 56) p.push_back(8'h00);
      for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
      nb = p.size() / 64;
      for (int b = 0; b < nb; b++) begin
         r.data = '0;
         for (int i = 0; i < 64; i++) r.data[511 - 8*i -: 8] = p[64*b + i];
         r.first = (b == 0);
         r.last  = (b == nb - 1);
         exp_q.push_back(r);
      end
   endfunction

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_byte      = b;
      rx_done_tick = 1'b1;
      @(posedge clk);
      #1;
      rx_done_tick = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int c = 0;
      while (busy && c < 4000) begin
         @(posedge clk);
         #1;
         c++;
      end
      chk({nm, " drain"}, 512'(busy), 512'(0));
      tick(2);
   endtask

   task automatic compare_msg(input string nm);
      build_exp();
      chk({nm, " nblk"}, 512'(got_q.size()), 512'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         chk($sformatf("%s blk%0d data", nm, i), got_q[i].data, exp_q[i].data);
         chk($sformatf("%s blk%0d first", nm, i), 512'(got_q[i].first), 512'(exp_q[i].first));
         chk($sformatf("%s blk%0d last", nm, i), 512'(got_q[i].last), 512'(exp_q[i].last));
      end
      got_q.delete();
   endtask

   task automatic send_abc();
      msg_q.delete();
      for (int i = 0; i < 3; i++) begin
         msg_q.push_back(8'h61 + 8'(i));
         send_byte(8'h61 + 8'(i));
         if (i != 2) tick(1);
      end
   endtask

   vec_t       vt[9];
   logic [7:0] b;
   int         cyc;
   int         n;

   initial begin
      vt[0] = '{1,   8'h55, 1'b0, 1, 64'd8};
      vt[1] = '{55,  8'h10, 1'b1, 1, 64'd440};
      vt[2] = '{56,  8'h61, 1'b0, 2, 64'h1C0};
      vt[3] = '{63,  8'h20, 1'b1, 2, 64'd504};
      vt[4] = '{64,  8'h00, 1'b1, 2, 64'h200};
      vt[5] = '{65,  8'hC0, 1'b1, 2, 64'd520};
      vt[6] = '{119, 8'h33, 1'b1, 2, 64'd952};
      vt[7] = '{120, 8'hF0, 1'b0, 3, 64'd960};
      vt[8] = '{128, 8'h01, 1'b1, 3, 64'd1024};

      // Reset values
      rdy_mode = 1;
      tick(3);
      @(negedge clk);
      chk("rst valid", 512'(blk_valid), 512'(0));
      chk("rst first", 512'(blk_first), 512'(0));
      chk("rst last", 512'(blk_last), 512'(0));
      chk("rst busy", 512'(busy), 512'(0));
      chk("rst overrun", 512'(overrun), 512'(0));
      chk("rst data", blk_data, 512'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(2);

      // "abc": single padded block, timeout latency
      send_abc();
      cyc = 0;
      while (!blk_valid && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("abc timeout latency", 512'(cyc), 512'(TO + 1));
      wait_idle("abc");
      if (got_q.size() > 0)
         chk("abc literal", got_q[0].data, {24'h616263, 8'h80, 416'h0, 64'h18});
      compare_msg("abc");

      // Length table around block boundaries
      for (int v = 0; v < 9; v++) begin
         msg_q.delete();
         for (int i = 0; i < int'(vt[v].len); i++) begin
            b = fix(vt[v].incr ? vt[v].base + 8'(i) : vt[v].base);
            msg_q.push_back(b);
            send_byte(b);
            tick(1);
         end
         wait_idle($sformatf("tbl%0d", v));
         chk($sformatf("tbl%0d count", v), 512'(got_q.size()), 512'(vt[v].nblk));
         if (got_q.size() > 0)
            chk($sformatf("tbl%0d lenfield", v), 512'(got_q[got_q.size()-1].data[63:0]),
                512'(vt[v].len_bits));
         compare_msg($sformatf("tbl%0d", v));
      end

      // Back-pressure: held byte kept, second byte dropped
      rdy_mode = 0;
      tick(3);
      msg_q.delete();
      for (int i = 0; i < 64; i++) begin
         b = fix(8'(i));
         msg_q.push_back(b);
         send_byte(b);
         if (i != 63) tick(1);
      end
      chk("bp byte64 latency", 512'(blk_valid), 512'(1));
      tick(100);
      b = fix(8'hA5);
      msg_q.push_back(b);
      send_byte(b);
      tick(2);
      chk("bp overrun after hold", 512'(overrun), 512'(0));
      tick(98);
      send_byte(8'h5A);
      tick(2);
      chk("bp overrun after drop", 512'(overrun), 512'(1));
      chk("bp valid stalled", 512'(blk_valid), 512'(1));
      chk("bp first stalled", 512'(blk_first), 512'(1));
      build_exp();
      chk("bp data stalled", blk_data, exp_q[0].data);
      chk("bp nothing accepted", 512'(got_q.size()), 512'(0));
      rdy_mode = 1;
      wait_idle("bp");
      compare_msg("bp");
      chk("bp overrun sticky", 512'(overrun), 512'(1));

      // Reset in the middle of a message
      msg_q.delete();
      for (int i = 0; i < 10; i++) begin
         send_byte(8'h40 + 8'(i));
         tick(1);
      end
      rst_n = 1'b0;
      tick(2);
      @(negedge clk);
      chk("midrst valid", 512'(blk_valid), 512'(0));
      chk("midrst busy", 512'(busy), 512'(0));
      chk("midrst overrun", 512'(overrun), 512'(0));
      chk("midrst data", blk_data, 512'(0));
      chk("midrst first", 512'(blk_first), 512'(0));
      chk("midrst last", 512'(blk_last), 512'(0));
      chk("midrst no block", 512'(got_q.size()), 512'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(2);
      send_abc();
      wait_idle("abc2");
      if (got_q.size() > 0) begin
         chk("abc2 literal", got_q[0].data, {24'h616263, 8'h80, 416'h0, 64'h18});
         chk("abc2 first", 512'(got_q[0].first), 512'(1));
      end
      compare_msg("abc2");

      // Terminator character
      msg_q.delete();
`ifdef SHA1_RX_EOM_CHAR_EN
      send_byte(8'h0A);
      wait_idle("eom");
      if (got_q.size() > 0) chk("eom empty literal", got_q[0].data, {8'h80, 504'h0});
`else
      msg_q.push_back(8'h0A);
      send_byte(8'h0A);
      wait_idle("eom");
      if (got_q.size() > 0)
         chk("eom as data literal", got_q[0].data, {8'h0A, 8'h80, 432'h0, 64'h8});
`endif
      compare_msg("eom");

      // Random messages, ready high, short gaps
      rdy_mode = 1;
      for (int m = 0; m < 6; m++) begin
         n = int'($urandom_range(1, 150));
         msg_q.delete();
         for (int i = 0; i < n; i++) begin
            b = fix(8'($urandom));
            msg_q.push_back(b);
            send_byte(b);
            tick(int'($urandom_range(1, 3)));
         end
         wait_idle($sformatf("rndA%0d", m));
         compare_msg($sformatf("rndA%0d", m));
      end

      // Random messages with random ready
      rdy_mode = 2;
      for (int m = 0; m < 6; m++) begin
         n = int'($urandom_range(1, 150));
         msg_q.delete();
         for (int i = 0; i < n; i++) begin
            b = fix(8'($urandom));
            msg_q.push_back(b);
            send_byte(b);
            tick(int'($urandom_range(4, 10)));
         end
         wait_idle($sformatf("rndB%0d", m));
         compare_msg($sformatf("rndB%0d", m));
      end
      chk("rnd overrun", 512'(overrun), 512'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
